spart_rx_bus_if: RTL and testbench

Downstream consumer of the SPART serial receiver.
- Takes each completed byte (rx_data qualified by rda) and acknowledges it with clr_rda.
- Buffers bytes in a small synchronous FIFO.
- Presents the buffered bytes and a status register to the processor over the SPART I/O bus (iocs/iorw/ioaddr).
- Lets the processor tolerate several byte times of latency without losing data.

---
 rtl/spart_pkg.sv | 20 ++
 rtl/spart_rx_fifo.sv | 64 ++++++
 rtl/spart_rx_bus_if.sv | 126 ++++++++++++
 tb/tb_spart_rx_bus_if.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared constants and types for the SPART receive-side bus interface.
package spart_pkg;

    // Processor-visible register addresses
    localparam logic [1:0] ADDR_RXDATA = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;

    // Bit positions inside the status byte
    localparam int ST_NEMPTY  = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVR     = 2;
    localparam int ST_CNT_LSB = 4;

    // Capture handshake with the serial receiver
    typedef enum logic {
        CAP_IDLE = 1'b0,
        CAP_ACK  = 1'b1
    } cap_state_t;

endpackage

// File: rtl/spart_rx_fifo.sv
// Small synchronous FIFO for received bytes. The head is presented
// combinationally; a pop on empty and a push on full without a pop are ignored.
module spart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [7:0]    mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push then
    assign do_pop  = pop && (count_reg != '0);
    assign do_push = push && ((count_reg != FULL_CNT) || do_pop);

    // Storage: each entry loads when the write pointer selects it
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_reg == AW'(gi))) begin
                    mem_reg[gi] <= din;
                end
            end
        end
    endgenerate

    // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign dout  = mem_reg[rd_ptr_reg];
    assign full  = (count_reg == FULL_CNT);
    assign empty = (count_reg == '0);
    assign count = count_reg;

endmodule

// File: rtl/spart_rx_bus_if.sv
// Receive-side bus interface: captures bytes from the SPART receiver into a
// FIFO and exposes the data and a status byte on the processor I/O bus.
module spart_rx_bus_if
    import spart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rda,
    output logic       clr_rda,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       rx_irq,
    output logic       overrun
);

    cap_state_t  state_reg, state_next;
    logic        push_req;
    logic        rd_pop;
    logic        ovr_set;
    logic        ovr_clr;
    logic        overrun_reg;
    logic        rx_irq_reg;
    logic [7:0]  rd_data_reg;
    logic [7:0]  status;
    logic [7:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic [AW:0] fifo_count;
    logic        unused_wr_bits;

    spart_rx_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (rd_pop),
        .din   (rx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rd_pop  = iocs && iorw && (ioaddr == ADDR_RXDATA);
    assign ovr_clr = iocs && !iorw && (ioaddr == ADDR_STATUS) && wr_data[ST_OVR];
    // Only the overrun-clear bit of a status write carries meaning
    assign unused_wr_bits = ^{wr_data[7:3], wr_data[1:0]};

    // Capture state register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= CAP_IDLE;
        else     state_reg <= state_next;
    end

    // Capture next state: one push per rda assertion, ack held until rda drops
    always_comb begin
        state_next = state_reg;
        push_req   = 1'b0;
        ovr_set    = 1'b0;
        clr_rda    = 1'b0;
        case (state_reg)
            CAP_IDLE: begin
                if (rda) begin
                    push_req   = 1'b1;
                    // A same-cycle pop makes room, so only a full FIFO without a pop drops the byte
                    ovr_set    = fifo_full && !rd_pop;
                    state_next = CAP_ACK;
                end
            end
            CAP_ACK: begin
                clr_rda = 1'b1;
                if (!rda) state_next = CAP_IDLE;
            end
            default: state_next = CAP_IDLE;
        endcase
    end

    // Sticky overrun flag; a set in the same cycle as a clear wins
    always_ff @(posedge clk) begin
        if (rst)          overrun_reg <= 1'b0;
        else if (ovr_set) overrun_reg <= 1'b1;
        else if (ovr_clr) overrun_reg <= 1'b0;
    end

    // Status byte assembled from live FIFO state
    always_comb begin
        status                 = '0;
        status[ST_NEMPTY]      = !fifo_empty;
        status[ST_FULL]        = fifo_full;
        status[ST_OVR]         = overrun_reg;
        status[7:ST_CNT_LSB]   = 4'(fifo_count);
    end

    // Registered read data; holds when there is no read access
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg <= 8'h00;
        end else if (iocs && iorw) begin
            case (ioaddr)
                ADDR_RXDATA: rd_data_reg <= fifo_empty ? 8'h00 : fifo_dout;
                ADDR_STATUS: rd_data_reg <= status;
                default:     rd_data_reg <= 8'h00;
            endcase
        end
    end

    // Interrupt follows occupancy one cycle later
    always_ff @(posedge clk) begin
        if (rst) rx_irq_reg <= 1'b0;
        else     rx_irq_reg <= (fifo_count != '0);
    end

    assign rd_data = rd_data_reg;
    assign rx_irq  = rx_irq_reg;
    assign overrun = overrun_reg;

endmodule

// File: tb/tb_spart_rx_bus_if.sv
// Directed bench for spart_rx_bus_if: capture handshake, FIFO fill/overrun,
// register reads/writes, simultaneous push/pop and mid-operation reset.
module tb_spart_rx_bus_if;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rda;
    logic       clr_rda;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       rx_irq;
    logic       overrun;

    int n_assert = 0;
    int n_fail   = 0;

    spart_rx_bus_if #(.DEPTH(8), .AW(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .rx_data (rx_data),
        .rda     (rda),
        .clr_rda (clr_rda),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .rx_irq  (rx_irq),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    // Advance one clock; everything is driven and sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One rda handshake: rda held one extra cycle after clr_rda rises, then dropped
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rda     = 1'b1;
        tick();
        check("clr_rda_rise", {7'b0, clr_rda}, 8'h01);
        tick();
        check("clr_rda_hold", {7'b0, clr_rda}, 8'h01);
        rda = 1'b0;
        tick();
        check("clr_rda_fall", {7'b0, clr_rda}, 8'h00);
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [7:0] d);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        tick();
        iocs = 1'b0;
        d = rd_data;
        $display("read  addr=%0d data=%h", a, d);
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; wr_data = d;
        tick();
        iocs = 1'b0; iorw = 1'b1;
        $display("write addr=%0d data=%h", a, d);
    endtask

    logic [7:0] d;
    logic [7:0] drain_exp [8];

    initial begin
        rst = 1'b1; rx_data = 8'h00; rda = 1'b0;
        iocs = 1'b0; iorw = 1'b1; ioaddr = 2'b00; wr_data = 8'h00;
        tick(); tick();
        rst = 1'b0;
        check("rst_clr_rda", {7'b0, clr_rda}, 8'h00);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_rx_irq",  {7'b0, rx_irq}, 8'h00);
        check("rst_overrun", {7'b0, overrun}, 8'h00);

        // Single byte
        send_byte(8'hA5);
        check("single_irq", {7'b0, rx_irq}, 8'h01);
        read_reg(2'b01, d); check("single_status", d, 8'h11);
        read_reg(2'b00, d); check("single_data", d, 8'hA5);
        tick();
        check("single_irq_fall", {7'b0, rx_irq}, 8'h00);

        // Fill and overrun
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        read_reg(2'b01, d); check("full_status", d, 8'h83);
        check("full_no_ovr", {7'b0, overrun}, 8'h00);
        send_byte(8'h09);
        check("ovr_flag", {7'b0, overrun}, 8'h01);
        read_reg(2'b01, d); check("ovr_status", d, 8'h87);
        for (int i = 1; i <= 8; i++) begin
            read_reg(2'b00, d); check("fill_drain", d, 8'(i));
        end
        read_reg(2'b01, d); check("drained_status", d, 8'h04);

        // Overrun clear
        write_reg(2'b01, 8'h00);
        check("ovr_keep", {7'b0, overrun}, 8'h01);
        write_reg(2'b01, 8'h04);
        check("ovr_clear", {7'b0, overrun}, 8'h00);
        read_reg(2'b01, d); check("clear_status", d, 8'h00);

        // Simultaneous push and pop with 3 queued
        send_byte(8'h10); send_byte(8'h11); send_byte(8'h12);
        rx_data = 8'h13; rda = 1'b1;
        iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00;
        tick();
        iocs = 1'b0;
        check("sim3_data", rd_data, 8'h10);
        tick(); rda = 1'b0; tick();
        read_reg(2'b01, d); check("sim3_status", d, 8'h31);
        read_reg(2'b00, d); check("sim3_next", d, 8'h11);

        // Refill to full (12,13 + 20..25), then simultaneous traffic at full
        for (int i = 0; i < 6; i++) send_byte(8'h20 + 8'(i));
        read_reg(2'b01, d); check("sim8_pre_status", d, 8'h83);
        rx_data = 8'h26; rda = 1'b1;
        iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00;
        tick();
        iocs = 1'b0;
        check("sim8_data", rd_data, 8'h12);
        tick(); rda = 1'b0; tick();
        check("sim8_no_ovr", {7'b0, overrun}, 8'h00);
        read_reg(2'b01, d); check("sim8_status", d, 8'h83);
        drain_exp = '{8'h13, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
        for (int i = 0; i < 8; i++) begin
            read_reg(2'b00, d); check("sim8_drain", d, drain_exp[i]);
        end

        // Empty read and unmapped addresses
        read_reg(2'b00, d); check("empty_read", d, 8'h00);
        read_reg(2'b01, d); check("empty_status", d, 8'h00);
        send_byte(8'h5A);
        read_reg(2'b01, d); check("one_status", d, 8'h11);
        tick();
        check("rd_hold", rd_data, 8'h11);
        read_reg(2'b11, d); check("addr3_read", d, 8'h00);
        read_reg(2'b01, d);
        read_reg(2'b10, d); check("addr2_read", d, 8'h00);
        read_reg(2'b00, d); check("one_data", d, 8'h5A);

        // Mid-operation reset with 5 queued (plus one captured) and FSM in ACK
        for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i));
        read_reg(2'b01, d); check("pre_rst_status", d, 8'h51);
        rx_data = 8'h35; rda = 1'b1;
        tick();
        check("pre_rst_ack", {7'b0, clr_rda}, 8'h01);
        rst = 1'b1; rda = 1'b0;
        tick();
        rst = 1'b0;
        check("mid_rst_clr_rda", {7'b0, clr_rda}, 8'h00);
        check("mid_rst_rd_data", rd_data, 8'h00);
        check("mid_rst_overrun", {7'b0, overrun}, 8'h00);
        check("mid_rst_irq", {7'b0, rx_irq}, 8'h00);
        read_reg(2'b01, d); check("mid_rst_status", d, 8'h00);
        send_byte(8'h77);
        read_reg(2'b00, d); check("post_rst_data", d, 8'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
